snn_io_ctrl: RTL and testbench
==============================

Name: snn_io_ctrl

Overview:
- Chip-clock-domain control block between host-fed dual-clock FIFOs (image, label, init, result) and the SNN core.
- Streams memory-init words from the init FIFO into the core.
- Delivers image and label data to the core through a 2-stage retiming pipeline.
- Reduces each 10-neuron output burst to an argmax class, pushes it into the result FIFO, and keeps debug counters.

Parameters:
- TEST_PIXEL, 6234: pixel index whose delivered image word is captured into image_test.
- NUM_CLASSES, 10: output beats per classification burst.

Ports:
- chip_clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- init_fifo_dout  in  15  bit14 = initialize flag, [13:0] = init value.
- init_fifo_empty  in  1  init FIFO empty.
- init_fifo_rd_en  out  1  constant 1.
- img_fifo_dout  in  4  four binary pixels.
- img_fifo_empty  in  1  image FIFO empty.
- img_fifo_rd_en  out  1  equals img_request.
- label_fifo_dout  in  4  label.
- label_fifo_rd_en  out  1  equals label_request.
- img_request  in  1  core pixel request.
- label_request  in  1  core label request.
- init_fin  in  1  core init done.
- output_valid  in  1  neuron burst beat valid.
- neuron_voltages  in  14  [13:10] = neuron index, [9:0] = signed voltage.
- image  out  32  expanded pixel word.
- label0  out  4  label to core.
- input_valid  out  1  image data valid.
- initialize  out  1  init write strobe.
- init_val  out  14  init data.
- out_fifo_din  out  4  argmax guess.
- out_fifo_wr_en  out  1  result push.
- lr_count, ir_count, ta_count, ov_count, init_count, init_empty_count, pixel_count  out  32 each  debug counters.
- image_test  out  32  captured word.
- mismatch  out  1  sticky index-error flag.

Behaviour:
- Reset (resetn=0 at chip_clk edge): all outputs, counters and internal registers clear to 0, except out_buf = 10'h200 (most-negative value). Reset overrides every other action.
- Input pipeline, every cycle:
  - Stage 1 registers valid = ~img_fifo_empty, lbl = label_fifo_dout, img = expand(img_fifo_dout).
  - Stage 2 registers stage 1 onto input_valid, label0, image.
  - Total latency 2 cycles.
  - expand(d) = {8{d[0]},8{d[1]},8{d[2]},8{d[3]}}; d[0] maps to image[31:24].
- Init / run control, priority order:
  - If init_fin: initialize<=0. If img_request, pixel_count++. If img_request & input_valid & pixel_count==TEST_PIXEL, image_test<=image.
  - Else if init_fifo_empty: if initialize=1, initialize<=0; otherwise init_empty_count++.
  - Else: init_val<=init_fifo_dout[13:0], initialize<=init_fifo_dout[14].
  - init_count++ on every cycle the registered initialize is 1.
- Output classifier, with internal out_count[3:0], out_buf[9:0] signed, out_guess[3:0]:
  - output_valid=1:
    - ov_count++.
    - If signed V[9:0] > signed out_buf (strict): out_buf<=V, out_guess<=out_count. Ties keep the lower index.
    - out_count++ (wraps mod 16).
    - If V[13:10] != out_count, mismatch<=1. mismatch clears only on reset.
    - out_fifo_wr_en <= (out_count==NUM_CLASSES-1); otherwise 0.
  - output_valid=0: out_fifo_wr_en<=0, out_count<=0, out_guess<=0, out_buf<=10'h200.
  - out_fifo_din = out_guess. During the wr_en cycle it already includes beat 9.
  - A burst longer than 16 beats pushes again at each wrap of index 9.
- Counters, all 32-bit and wrapping:
  - lr_count++ on label_request.
  - ir_count++ on img_request.
  - ta_count++ on stage-1 valid & img_request.

Optional Feature:
- Macro: SNN_IO_DEBUG_CNT_EN.
- Defined: all debug counters and image_test behave as specified.
- Undefined: those outputs are tied to 0 and their registers are removed. mismatch and all datapath behaviour are unchanged.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with FIFO non-empty -> all outputs 0, initialize=0. Release -> input_valid rises 2 cycles after img_fifo_empty=0.
- Expansion: img_fifo_dout=4'b0101, not empty -> image=32'hFF00FF00 and input_valid=1 two cycles later. label_fifo_dout=7 -> label0=7 two cycles later.
- Init stream: init_fifo_dout=15'h4123 for 3 cycles, then empty, init_fin=0 -> initialize=1, init_val=14'h0123, init_count=3. Next empty cycle -> initialize=0. Following empty cycles -> init_empty_count increments.
- Classifier: 10 beats, index i, voltages {-5,3,-512,100,100,7,0,-1,50,99} -> out_fifo_wr_en pulses once, 1 cycle after beat 9, out_fifo_din=3, mismatch=0, ov_count=10.
- Mismatch / short burst: beat 2 carries index 5 -> mismatch=1, sticky until reset. Burst of only 6 beats -> no wr_en; out_count returns to 0 next idle cycle.
- Run capture: init_fin=1, img_request=1 continuously, valid data -> pixel_count counts up; image_test holds image from the cycle pixel_count==6234.

Source files
------------

// File: rtl/snn_io_ctrl_if.sv
// snn_io_ctrl_if
//   FIFO-side bundle of snn_io_ctrl: the host-fed init/image/label FIFO read
//   ports and the result FIFO write port.
//   master : the control block (reads init/image/label FIFOs, writes results)
//   slave  : the FIFO side
//   Signals:
//     init_fifo_dout[14:0]  bit14 = initialize flag, [13:0] = init value
//     init_fifo_empty       init FIFO empty
//     init_fifo_rd_en       init FIFO read enable
//     img_fifo_dout[3:0]    four binary pixels
//     img_fifo_empty        image FIFO empty
//     img_fifo_rd_en        image FIFO read enable
//     label_fifo_dout[3:0]  label
//     label_fifo_rd_en      label FIFO read enable
//     out_fifo_din[3:0]     argmax class guess
//     out_fifo_wr_en        result FIFO push
interface snn_io_ctrl_if;
    logic [14:0] init_fifo_dout;
    logic        init_fifo_empty;
    logic        init_fifo_rd_en;
    logic [3:0]  img_fifo_dout;
    logic        img_fifo_empty;
    logic        img_fifo_rd_en;
    logic [3:0]  label_fifo_dout;
    logic        label_fifo_rd_en;
    logic [3:0]  out_fifo_din;
    logic        out_fifo_wr_en;

    modport master (
        input  init_fifo_dout, init_fifo_empty, img_fifo_dout, img_fifo_empty,
               label_fifo_dout,
        output init_fifo_rd_en, img_fifo_rd_en, label_fifo_rd_en,
               out_fifo_din, out_fifo_wr_en
    );

    modport slave (
        output init_fifo_dout, init_fifo_empty, img_fifo_dout, img_fifo_empty,
               label_fifo_dout,
        input  init_fifo_rd_en, img_fifo_rd_en, label_fifo_rd_en,
               out_fifo_din, out_fifo_wr_en
    );
endinterface

// File: rtl/snn_io_ctrl.sv
// snn_io_ctrl
//   Chip-clock-domain control between the host FIFOs and the SNN core.
//   - streams memory-init words from the init FIFO into the core
//   - delivers image/label data through a 2-stage retiming pipeline
//   - reduces each 10-beat neuron output burst to an argmax class and pushes
//     it into the result FIFO; keeps a sticky index-error flag
//   Optional: define SNN_IO_DEBUG_CNT_EN to build the debug counters and the
//   image_test capture; otherwise those outputs are tied to 0.
//   Ports:
//     chip_clk, resetn (sync, active-low)
//     fifo           FIFO bundle (snn_io_ctrl_if.master)
//     img_request, label_request, init_fin      core handshakes
//     output_valid, neuron_voltages[13:0]       neuron burst ([13:10] idx)
//     image[31:0], label0[3:0], input_valid     data to core
//     initialize, init_val[13:0]                init write to core
//     lr/ir/ta/ov/init/init_empty/pixel _count  debug counters (32 bit)
//     image_test[31:0]                          captured word at TEST_PIXEL
//     mismatch                                  sticky burst index error
module snn_io_ctrl #(
    parameter int unsigned TEST_PIXEL  = 6234,
    parameter int unsigned NUM_CLASSES = 10
) (
    input  logic                 chip_clk,
    input  logic                 resetn,
    snn_io_ctrl_if.master        fifo,
    input  logic                 img_request,
    input  logic                 label_request,
    input  logic                 init_fin,
    input  logic                 output_valid,
    input  logic [13:0]          neuron_voltages,
    output logic [31:0]          image,
    output logic [3:0]           label0,
    output logic                 input_valid,
    output logic                 initialize,
    output logic [13:0]          init_val,
    output logic [31:0]          lr_count,
    output logic [31:0]          ir_count,
    output logic [31:0]          ta_count,
    output logic [31:0]          ov_count,
    output logic [31:0]          init_count,
    output logic [31:0]          init_empty_count,
    output logic [31:0]          pixel_count,
    output logic [31:0]          image_test,
    output logic                 mismatch
);

    logic        r_s1_valid;
    logic [3:0]  r_s1_lbl;
    logic [31:0] r_s1_img;
    logic        r_input_valid;
    logic [3:0]  r_label0;
    logic [31:0] r_image;
    logic        r_initialize;
    logic [13:0] r_init_val;

    logic [3:0]        r_out_count;
    logic signed [9:0] r_out_buf;
    logic [3:0]        r_out_guess;
    logic              r_out_wr_en;
    logic              r_mismatch;

    logic [31:0]       w_expand;
    logic signed [9:0] w_volt;
    logic [3:0]        w_idx;

    // d[0] lands in the top byte
    assign w_expand = {{8{fifo.img_fifo_dout[0]}}, {8{fifo.img_fifo_dout[1]}},
                       {8{fifo.img_fifo_dout[2]}}, {8{fifo.img_fifo_dout[3]}}};
    assign w_volt   = neuron_voltages[9:0];
    assign w_idx    = neuron_voltages[13:10];

    assign fifo.init_fifo_rd_en  = 1'b1;
    assign fifo.img_fifo_rd_en   = img_request;
    assign fifo.label_fifo_rd_en = label_request;
    assign fifo.out_fifo_din     = r_out_guess;
    assign fifo.out_fifo_wr_en   = r_out_wr_en;

    assign image       = r_image;
    assign label0      = r_label0;
    assign input_valid = r_input_valid;
    assign initialize  = r_initialize;
    assign init_val    = r_init_val;
    assign mismatch    = r_mismatch;

    always_ff @(posedge chip_clk) begin
        if (!resetn) begin
            r_s1_valid    <= 1'b0;
            r_s1_lbl      <= '0;
            r_s1_img      <= '0;
            r_input_valid <= 1'b0;
            r_label0      <= '0;
            r_image       <= '0;
        end else begin
            r_s1_valid    <= ~fifo.img_fifo_empty;
            r_s1_lbl      <= fifo.label_fifo_dout;
            r_s1_img      <= w_expand;
            r_input_valid <= r_s1_valid;
            r_label0      <= r_s1_lbl;
            r_image       <= r_s1_img;
        end
    end

    // Init streaming stops once the core reports init done; an empty FIFO
    // drops the strobe after one idle cycle.
    always_ff @(posedge chip_clk) begin
        if (!resetn) begin
            r_initialize <= 1'b0;
            r_init_val   <= '0;
        end else if (init_fin) begin
            r_initialize <= 1'b0;
        end else if (fifo.init_fifo_empty) begin
            r_initialize <= 1'b0;
        end else begin
            r_init_val   <= fifo.init_fifo_dout[13:0];
            r_initialize <= fifo.init_fifo_dout[14];
        end
    end

    // Running argmax over a burst; strict compare keeps the lowest index on
    // ties. out_guess is updated on the same edge as wr_en, so the pushed
    // value already accounts for the final beat.
    always_ff @(posedge chip_clk) begin
        if (!resetn) begin
            r_out_count <= '0;
            r_out_buf   <= 10'h200;
            r_out_guess <= '0;
            r_out_wr_en <= 1'b0;
            r_mismatch  <= 1'b0;
        end else if (output_valid) begin
            if (w_volt > r_out_buf) begin
                r_out_buf   <= w_volt;
                r_out_guess <= r_out_count;
            end
            r_out_count <= r_out_count + 4'd1;
            if (w_idx != r_out_count)
                r_mismatch <= 1'b1;
            r_out_wr_en <= (r_out_count == 4'(NUM_CLASSES - 1));
        end else begin
            r_out_count <= '0;
            r_out_buf   <= 10'h200;
            r_out_guess <= '0;
            r_out_wr_en <= 1'b0;
        end
    end

`ifdef SNN_IO_DEBUG_CNT_EN
    logic [31:0] r_lr_count, r_ir_count, r_ta_count, r_ov_count;
    logic [31:0] r_init_count, r_init_empty_count, r_pixel_count;
    logic [31:0] r_image_test;

    always_ff @(posedge chip_clk) begin
        if (!resetn) begin
            r_lr_count         <= '0;
            r_ir_count         <= '0;
            r_ta_count         <= '0;
            r_ov_count         <= '0;
            r_init_count       <= '0;
            r_init_empty_count <= '0;
            r_pixel_count      <= '0;
            r_image_test       <= '0;
        end else begin
            if (label_request)            r_lr_count   <= r_lr_count + 32'd1;
            if (img_request)              r_ir_count   <= r_ir_count + 32'd1;
            if (r_s1_valid & img_request) r_ta_count   <= r_ta_count + 32'd1;
            if (output_valid)             r_ov_count   <= r_ov_count + 32'd1;
            if (r_initialize)             r_init_count <= r_init_count + 32'd1;
            // Mirrors the init-control priority: run-phase counting only
            // after init_fin, idle counting only on a truly idle empty cycle.
            if (init_fin) begin
                if (img_request)
                    r_pixel_count <= r_pixel_count + 32'd1;
                if (img_request && r_input_valid && r_pixel_count == 32'(TEST_PIXEL))
                    r_image_test <= r_image;
            end else if (fifo.init_fifo_empty && !r_initialize) begin
                r_init_empty_count <= r_init_empty_count + 32'd1;
            end
        end
    end

    assign lr_count         = r_lr_count;
    assign ir_count         = r_ir_count;
    assign ta_count         = r_ta_count;
    assign ov_count         = r_ov_count;
    assign init_count       = r_init_count;
    assign init_empty_count = r_init_empty_count;
    assign pixel_count      = r_pixel_count;
    assign image_test       = r_image_test;
`else
    assign lr_count         = '0;
    assign ir_count         = '0;
    assign ta_count         = '0;
    assign ov_count         = '0;
    assign init_count       = '0;
    assign init_empty_count = '0;
    assign pixel_count      = '0;
    assign image_test       = '0;
`endif

endmodule

// File: tb/tb_snn_io_ctrl.sv
// tb_snn_io_ctrl
//   Directed plus randomized stimulus for snn_io_ctrl, checked every cycle
//   against a behavioural reference model, with extra directed checks for the
//   specific scenarios of interest.
module tb_snn_io_ctrl;

    localparam int unsigned TEST_PIXEL = 6234;
`ifdef SNN_IO_DEBUG_CNT_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic        chip_clk = 1'b0;
    logic        resetn;
    logic        img_request, label_request, init_fin, output_valid;
    logic [13:0] neuron_voltages;
    logic [31:0] image, image_test;
    logic [3:0]  label0;
    logic        input_valid, initialize, mismatch;
    logic [13:0] init_val;
    logic [31:0] lr_count, ir_count, ta_count, ov_count;
    logic [31:0] init_count, init_empty_count, pixel_count;

    int ncmp = 0;
    int nfail = 0;

    snn_io_ctrl_if fifo_bus ();

    snn_io_ctrl #(.TEST_PIXEL(TEST_PIXEL), .NUM_CLASSES(10)) dut (
        .chip_clk(chip_clk), .resetn(resetn), .fifo(fifo_bus),
        .img_request(img_request), .label_request(label_request),
        .init_fin(init_fin), .output_valid(output_valid),
        .neuron_voltages(neuron_voltages), .image(image), .label0(label0),
        .input_valid(input_valid), .initialize(initialize), .init_val(init_val),
        .lr_count(lr_count), .ir_count(ir_count), .ta_count(ta_count),
        .ov_count(ov_count), .init_count(init_count),
        .init_empty_count(init_empty_count), .pixel_count(pixel_count),
        .image_test(image_test), .mismatch(mismatch)
    );

    always #5 chip_clk = ~chip_clk;

    // ---------------- reference model ----------------
    logic        m_s1_valid, m_iv, m_init, m_mm, m_wr;
    logic [3:0]  m_s1_lbl, m_lbl, m_s1_d, m_d, m_guess;
    logic [13:0] m_init_val;
    logic [31:0] m_lr, m_ir, m_ta, m_ov, m_initc, m_iempty, m_pix, m_imgtest;
    int          q[$];   // voltages of the current burst, in arrival order

    function automatic logic [31:0] expand_ref(input logic [3:0] d);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            if (d[k]) w = w | (32'hFF << (24 - 8 * k));
        return w;
    endfunction

    // First position holding the burst maximum, reported modulo 16.
    function automatic logic [3:0] burst_guess();
        int best;
        best = 0;
        for (int p = 1; p < q.size(); p++)
            if (q[p] > q[best]) best = p;
        return 4'(best % 16);
    endfunction

    task automatic model();
        logic cap;
        int   pos;
        if (!resetn) begin
            {m_s1_valid, m_iv, m_init, m_mm, m_wr} = '0;
            {m_s1_lbl, m_lbl, m_s1_d, m_d, m_guess} = '0;
            m_init_val = '0;
            {m_lr, m_ir, m_ta, m_ov, m_initc, m_iempty, m_pix, m_imgtest} = '0;
            q.delete();
        end else begin
            cap = init_fin && img_request && m_iv && (m_pix == TEST_PIXEL);
            if (label_request)             m_lr++;
            if (img_request)               m_ir++;
            if (m_s1_valid && img_request) m_ta++;
            if (output_valid)              m_ov++;
            if (m_init)                    m_initc++;
            if (init_fin) begin
                if (img_request) m_pix++;
                if (cap) m_imgtest = expand_ref(m_d);
                m_init = 1'b0;
            end else if (fifo_bus.init_fifo_empty) begin
                if (m_init) m_init = 1'b0;
                else        m_iempty++;
            end else begin
                m_init_val = fifo_bus.init_fifo_dout[13:0];
                m_init     = fifo_bus.init_fifo_dout[14];
            end
            m_iv = m_s1_valid; m_lbl = m_s1_lbl; m_d = m_s1_d;
            m_s1_valid = !fifo_bus.img_fifo_empty;
            m_s1_lbl   = fifo_bus.label_fifo_dout;
            m_s1_d     = fifo_bus.img_fifo_dout;
            if (output_valid) begin
                pos = q.size();
                if (neuron_voltages[13:10] != 4'(pos % 16)) m_mm = 1'b1;
                m_wr = (pos % 16 == 9);
                q.push_back(int'($signed(neuron_voltages[9:0])));
                m_guess = burst_guess();
            end else begin
                q.delete();
                m_wr = 1'b0;
                m_guess = '0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("image", image, expand_ref(m_d));
        chk("label0", 32'(label0), 32'(m_lbl));
        chk("input_valid", 32'(input_valid), 32'(m_iv));
        chk("initialize", 32'(initialize), 32'(m_init));
        chk("init_val", 32'(init_val), 32'(m_init_val));
        chk("out_fifo_wr_en", 32'(fifo_bus.out_fifo_wr_en), 32'(m_wr));
        chk("out_fifo_din", 32'(fifo_bus.out_fifo_din), 32'(m_guess));
        chk("mismatch", 32'(mismatch), 32'(m_mm));
        chk("init_fifo_rd_en", 32'(fifo_bus.init_fifo_rd_en), 32'd1);
        chk("img_fifo_rd_en", 32'(fifo_bus.img_fifo_rd_en), 32'(img_request));
        chk("label_fifo_rd_en", 32'(fifo_bus.label_fifo_rd_en), 32'(label_request));
        chk("lr_count", lr_count, DBG ? m_lr : 32'd0);
        chk("ir_count", ir_count, DBG ? m_ir : 32'd0);
        chk("ta_count", ta_count, DBG ? m_ta : 32'd0);
        chk("ov_count", ov_count, DBG ? m_ov : 32'd0);
        chk("init_count", init_count, DBG ? m_initc : 32'd0);
        chk("init_empty_count", init_empty_count, DBG ? m_iempty : 32'd0);
        chk("pixel_count", pixel_count, DBG ? m_pix : 32'd0);
        chk("image_test", image_test, DBG ? m_imgtest : 32'd0);
    endtask

    // One clock: model and DUT both advance on the edge, compare #1 later.
    task automatic step();
        @(posedge chip_clk);
        model();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
    endtask

    int          volts[10] = '{-5, 3, -512, 100, 100, 7, 0, -1, 50, 99};
    int          bpos;
    logic [3:0]  data[0:6299];

    initial begin
        resetn = 1'b0;
        img_request = 1'b0; label_request = 1'b0; init_fin = 1'b0;
        output_valid = 1'b0; neuron_voltages = '0;
        fifo_bus.init_fifo_dout = 15'h4123; fifo_bus.init_fifo_empty = 1'b0;
        fifo_bus.img_fifo_dout = 4'hA; fifo_bus.img_fifo_empty = 1'b0;
        fifo_bus.label_fifo_dout = 4'h3;
        #1;

        // Reset with FIFOs non-empty
        do_reset();
        chk("rst_initialize", 32'(initialize), 32'd0);
        chk("rst_image", image, 32'd0);
        chk("rst_input_valid", 32'(input_valid), 32'd0);
        fifo_bus.init_fifo_empty = 1'b1;
        step();
        chk("rel_valid_c1", 32'(input_valid), 32'd0);
        step();
        chk("rel_valid_c2", 32'(input_valid), 32'd1);

        // Expansion / label latency
        fifo_bus.img_fifo_dout = 4'b0101; fifo_bus.label_fifo_dout = 4'd7;
        step(); step();
        chk("exp_image", image, 32'hFF00FF00);
        chk("exp_label", 32'(label0), 32'd7);

        // Init stream
        fifo_bus.init_fifo_dout = 15'h4123; fifo_bus.init_fifo_empty = 1'b0;
        do_reset();
        repeat (3) step();
        chk("init_strobe", 32'(initialize), 32'd1);
        chk("init_val_dir", 32'(init_val), 32'h0123);
        fifo_bus.init_fifo_empty = 1'b1;
        step();
        chk("init_drop", 32'(initialize), 32'd0);
        if (DBG) chk("init_count_dir", init_count, 32'd3);
        step(); step();
        if (DBG) chk("init_empty_dir", init_empty_count, 32'd2);

        // Classifier burst
        for (int i = 0; i < 10; i++) begin
            output_valid = 1'b1;
            neuron_voltages = {4'(i), 10'(volts[i])};
            step();
            if (i < 9) chk("cls_no_push", 32'(fifo_bus.out_fifo_wr_en), 32'd0);
        end
        chk("cls_push", 32'(fifo_bus.out_fifo_wr_en), 32'd1);
        chk("cls_guess", 32'(fifo_bus.out_fifo_din), 32'd3);
        chk("cls_mismatch", 32'(mismatch), 32'd0);
        if (DBG) chk("cls_ov_count", ov_count, 32'd10);
        output_valid = 1'b0;
        step();
        chk("cls_push_end", 32'(fifo_bus.out_fifo_wr_en), 32'd0);

        // Short burst with a bad index at beat 2
        for (int i = 0; i < 6; i++) begin
            output_valid = 1'b1;
            neuron_voltages = {(i == 2) ? 4'd5 : 4'(i), 10'(i * 3)};
            step();
            chk("short_no_push", 32'(fifo_bus.out_fifo_wr_en), 32'd0);
        end
        output_valid = 1'b0;
        step(); step();
        chk("mm_sticky", 32'(mismatch), 32'd1);
        do_reset();
        chk("mm_reset", 32'(mismatch), 32'd0);

        // Long burst: pushes at every pass of index 9
        for (int i = 0; i < 27; i++) begin
            output_valid = 1'b1;
            neuron_voltages = {4'(i % 16), 10'($urandom_range(0, 1023))};
            step();
        end
        output_valid = 1'b0;
        step();

        // Randomized traffic
        bpos = 0;
        for (int c = 0; c < 400; c++) begin
            fifo_bus.img_fifo_dout   = 4'($urandom);
            fifo_bus.img_fifo_empty  = ($urandom_range(0, 3) == 0);
            fifo_bus.label_fifo_dout = 4'($urandom);
            fifo_bus.init_fifo_dout  = 15'($urandom);
            fifo_bus.init_fifo_empty = ($urandom_range(0, 2) == 0);
            img_request   = 1'($urandom);
            label_request = 1'($urandom);
            init_fin      = ($urandom_range(0, 3) == 0);
            output_valid  = ($urandom_range(0, 7) != 0);
            if (output_valid) begin
                neuron_voltages = {($urandom_range(0, 40) == 0) ? 4'($urandom) : 4'(bpos % 16),
                                   10'($urandom)};
                bpos++;
            end else begin
                bpos = 0;
            end
            step();
        end

        // Run phase with capture at TEST_PIXEL
        output_valid = 1'b0; label_request = 1'b0;
        fifo_bus.img_fifo_empty = 1'b0; fifo_bus.init_fifo_empty = 1'b1;
        do_reset();
        init_fin = 1'b1; img_request = 1'b1;
        for (int j = 0; j < 6300; j++) begin
            data[j] = 4'($urandom);
            fifo_bus.img_fifo_dout = data[j];
            step();
        end
        if (DBG) begin
            chk("run_pixel_count", pixel_count, 32'd6300);
            chk("run_capture", image_test, expand_ref(data[TEST_PIXEL - 2]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
